// File: rtl/input_conditioner.sv
// Multi-channel conditioner for async board inputs: synchronise, debounce on a shared
// sample tick, then derive level, press/release edges, long-press and optional auto-repeat.
module input_conditioner #(
    parameter int unsigned      WIDTH          = 4,
    parameter int unsigned      SYNC_STAGES    = 2,
    parameter int unsigned      SAMPLE_CNT_MAX = 40000,
    parameter int unsigned      PULSE_CNT_MAX  = 200,
    parameter int unsigned      LONG_CNT       = 2000,
    parameter int unsigned      REPEAT_CNT     = 200,
    parameter logic [WIDTH-1:0] REPEAT_EN      = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] long_press
);

    localparam int unsigned TICK_W = $clog2(SAMPLE_CNT_MAX + 1);
    localparam int unsigned DEB_W  = $clog2(PULSE_CNT_MAX + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_CNT + 1);
    localparam int unsigned REP_W  = $clog2(REPEAT_CNT + 1);

    typedef enum logic {
        HELD_SHORT = 1'b0,
        HELD_LONG  = 1'b1
    } hold_state_e;

    logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]  s;
    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick;
    logic [WIDTH-1:0]  level_d;
    logic [WIDTH-1:0]  press_d;
    logic [WIDTH-1:0]  release_d;
    logic [WIDTH-1:0]  long_d;

    // Per-bit synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= in;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Shared sample-tick divider
    assign tick = (tick_cnt_q == TICK_W'(SAMPLE_CNT_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [DEB_W-1:0]  deb_q;
        logic [DEB_W-1:0]  deb_d;
        hold_state_e       state_q;
        hold_state_e       state_d;
        logic [HOLD_W-1:0] hold_q;
        logic [HOLD_W-1:0] hold_d;
        logic [REP_W-1:0]  rep_q;
        logic [REP_W-1:0]  rep_d;
        logic              long_hit;
        logic              rep_fire;

        // Debounce: count consecutive high ticks, clear on any low tick
        always_comb begin
            deb_d = deb_q;
            if (tick) begin
                if (!s[i]) begin
                    deb_d = '0;
                end else if (deb_q != DEB_W'(PULSE_CNT_MAX)) begin
                    deb_d = deb_q + 1'b1;
                end
            end
        end

        // Hold classification: short hold until LONG_CNT ticks, then optional repeats
        always_comb begin
            state_d  = state_q;
            hold_d   = hold_q;
            rep_d    = rep_q;
            long_hit = 1'b0;
            rep_fire = 1'b0;
            if (!level[i]) begin
                state_d = HELD_SHORT;
                hold_d  = '0;
                rep_d   = '0;
            end else if (tick) begin
                case (state_q)
                    HELD_SHORT: begin
                        hold_d = hold_q + 1'b1;
                        if (hold_q == HOLD_W'(LONG_CNT - 1)) begin
                            long_hit = 1'b1;
                            state_d  = HELD_LONG;
                            rep_d    = '0;
                        end
                    end
                    HELD_LONG: begin
                        if (REPEAT_EN[i]) begin
                            if (rep_q == REP_W'(REPEAT_CNT - 1)) begin
                                rep_d    = '0;
                                rep_fire = 1'b1;
                            end else begin
                                rep_d = rep_q + 1'b1;
                            end
                        end
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                deb_q   <= '0;
                state_q <= HELD_SHORT;
                hold_q  <= '0;
                rep_q   <= '0;
            end else begin
                deb_q   <= deb_d;
                state_q <= state_d;
                hold_q  <= hold_d;
                rep_q   <= rep_d;
            end
        end

        // A release on the same tick suppresses any repeat or long-press event
        assign level_d[i]   = (deb_d == DEB_W'(PULSE_CNT_MAX));
        assign release_d[i] = level[i] & ~level_d[i];
        assign press_d[i]   = level_d[i] & (~level[i] | rep_fire);
        assign long_d[i]    = long_hit & level_d[i];
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level         <= '0;
            press         <= '0;
            release_pulse <= '0;
            long_press    <= '0;
        end else begin
            level         <= level_d;
            press         <= press_d;
            release_pulse <= release_d;
            long_press    <= long_d;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: run-length reference model checked every cycle,
// plus directed scenarios with hand-computed cycle offsets.
module tb_input_conditioner;

    localparam int WIDTH  = 4;
    localparam int SYNC   = 2;
    localparam int SAMPLE = 4;
    localparam int PULSE  = 3;
    localparam int LONG   = 5;
    localparam int REP    = 2;
    localparam logic [WIDTH-1:0] REP_EN = 4'b0001;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic [WIDTH-1:0] in_v  = '0;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] press;
    logic [WIDTH-1:0] release_pulse;
    logic [WIDTH-1:0] long_press;

    int vec_cnt     = 0;
    int miscompares = 0;

    // Reference model state: run[i] = consecutive high sample ticks seen on channel i
    int               n_edge = 0;
    logic [WIDTH-1:0] sq[$];
    int               run [WIDTH];
    logic [WIDTH-1:0] m_s;
    logic [WIDTH-1:0] exp_level = '0;
    logic [WIDTH-1:0] exp_press = '0;
    logic [WIDTH-1:0] exp_rel   = '0;
    logic [WIDTH-1:0] exp_long  = '0;
    logic             prev_lvl;
    logic             new_lvl;
    int               since;

    int pc [WIDTH];
    int rc [WIDTH];
    int lc [WIDTH];
    int lv [WIDTH];

    input_conditioner #(
        .WIDTH          (WIDTH),
        .SYNC_STAGES    (SYNC),
        .SAMPLE_CNT_MAX (SAMPLE),
        .PULSE_CNT_MAX  (PULSE),
        .LONG_CNT       (LONG),
        .REPEAT_CNT     (REP),
        .REPEAT_EN      (REP_EN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in            (in_v),
        .level         (level),
        .press         (press),
        .release_pulse (release_pulse),
        .long_press    (long_press)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // Model: level after PULSE high ticks, long at PULSE+LONG, repeats every REP after that
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            n_edge = 0;
            sq.delete();
            for (int i = 0; i < WIDTH; i++) run[i] = 0;
            exp_level = '0;
            exp_press = '0;
            exp_rel   = '0;
            exp_long  = '0;
        end else begin
            n_edge++;
            m_s = (sq.size() == SYNC) ? sq[0] : '0;
            sq.push_back(in_v);
            if (sq.size() > SYNC) void'(sq.pop_front());
            exp_press = '0;
            exp_rel   = '0;
            exp_long  = '0;
            if (n_edge % SAMPLE == 0) begin
                for (int i = 0; i < WIDTH; i++) begin
                    prev_lvl     = (run[i] >= PULSE);
                    run[i]       = m_s[i] ? run[i] + 1 : 0;
                    new_lvl      = (run[i] >= PULSE);
                    since        = run[i] - PULSE - LONG;
                    exp_level[i] = new_lvl;
                    exp_rel[i]   = prev_lvl && !new_lvl;
                    exp_long[i]  = (since == 0);
                    exp_press[i] = (new_lvl && !prev_lvl) ||
                                   (REP_EN[i] && since > 0 && since % REP == 0);
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        vec_cnt++;
        if ({level, press, release_pulse, long_press} !==
            {exp_level, exp_press, exp_rel, exp_long}) begin
            miscompares++;
            $display("FAIL model @%0t: lvl/prs/rel/lng got %b/%b/%b/%b want %b/%b/%b/%b",
                     $time, level, press, release_pulse, long_press,
                     exp_level, exp_press, exp_rel, exp_long);
        end
    end

    function automatic int outs();
        return int'({level, press, release_pulse, long_press});
    endfunction

    task automatic check(input string name, input int act, input int want);
        vec_cnt++;
        if (act != want) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d want %0d", name, $time, act, want);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < WIDTH; i++) begin
            pc[i] = 0; rc[i] = 0; lc[i] = 0; lv[i] = 0;
        end
    endtask

    task automatic step_count(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < WIDTH; i++) begin
                pc[i] += int'(press[i]);
                rc[i] += int'(release_pulse[i]);
                lc[i] += int'(long_press[i]);
                lv[i] += int'(level[i]);
            end
        end
    endtask

    // Land on the falling edge right after a sample-tick edge
    task automatic sync_tick();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 2 * SAMPLE && !found; k++) begin
            @(negedge clk);
            if (n_edge > 0 && n_edge % SAMPLE == 0) found = 1'b1;
        end
        if (!found) begin
            vec_cnt++;
            miscompares++;
            $display("FAIL sync_tick: no tick edge within %0d cycles", 2 * SAMPLE);
        end
    endtask

    initial begin
        clear_counts();
        // Reset held while inputs toggle
        #1 rst_n = 1'b0;
        in_v = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("outs_in_reset", outs(), 0);
            in_v = ~in_v;
        end
        in_v = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("quiet_after_reset", outs(), 0);
        end

        // Glitch of two high ticks on ch1
        sync_tick();
        clear_counts();
        in_v[1] = 1'b1;
        step_count(8);
        in_v[1] = 1'b0;
        step_count(20);
        check("glitch_level1", lv[1], 0);
        check("glitch_press1", pc[1], 0);
        check("glitch_rel1", rc[1], 0);

        // Steady ch1: press 12 cycles after a tick-aligned rise, long 20 later
        sync_tick();
        in_v[1] = 1'b1;
        step_count(11);
        check("prequal_level1", int'(level[1]), 0);
        step_count(1);
        check("press1_rise", int'(press[1]), 1);
        check("level1_rise", int'(level[1]), 1);
        step_count(1);
        check("press1_single", int'(press[1]), 0);
        step_count(18);
        check("long1_early", int'(long_press[1]), 0);
        step_count(1);
        check("long1_fire", int'(long_press[1]), 1);
        clear_counts();
        step_count(30);
        check("ch1_no_repeat", pc[1], 0);
        check("ch1_long_once", lc[1], 0);
        sync_tick();
        in_v[1] = 1'b0;
        step_count(3);
        check("rel1_early", int'(release_pulse[1]), 0);
        step_count(1);
        check("rel1_fire", int'(release_pulse[1]), 1);
        check("level1_fall", int'(level[1]), 0);
        step_count(8);

        // Ch0 with repeat; drop so the low tick coincides with a repeat slot
        sync_tick();
        in_v[0] = 1'b1;
        step_count(12);
        check("press0_rise", int'(press[0]), 1);
        step_count(20);
        check("long0_fire", int'(long_press[0]), 1);
        check("press0_at_long", int'(press[0]), 0);
        step_count(8);
        check("repeat0_first", int'(press[0]), 1);
        step_count(1);
        check("repeat0_single", int'(press[0]), 0);
        step_count(4);
        in_v[0] = 1'b0;
        step_count(3);
        check("rel0_at_repeat", int'(release_pulse[0]), 1);
        check("press0_suppressed", int'(press[0]), 0);
        check("level0_fall", int'(level[0]), 0);
        step_count(8);

        // Ch0 and ch2 driven identically; only ch0 repeats
        sync_tick();
        clear_counts();
        in_v = 4'b0101;
        step_count(60);
        check("ch0_press_cnt", pc[0], 4);
        check("ch2_press_cnt", pc[2], 1);
        check("ch0_long_cnt", lc[0], 1);
        check("ch2_long_cnt", lc[2], 1);
        check("ch0_level_cycles", lv[0], 49);
        check("ch2_level_cycles", lv[2], 49);
        in_v = '0;
        step_count(20);

        // Reset during long hold with input still high
        sync_tick();
        in_v[1] = 1'b1;
        step_count(40);
        check("held_long_level1", int'(level[1]), 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("async_reset_outs", outs(), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        step_count(11);
        check("requal_level1", int'(level[1]), 0);
        step_count(1);
        check("requal_press1", int'(press[1]), 1);
        step_count(19);
        check("requal_long1_early", int'(long_press[1]), 0);
        step_count(1);
        check("requal_long1_fire", int'(long_press[1]), 1);
        in_v = '0;
        step_count(20);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
